// File: rtl/lab_pkg.sv
// Shared constants and the per-channel debug state type for the input debouncer.
package lab_pkg;

    localparam int STABLE_CNT_DEF = 4;
    localparam int CNT_W_DEF      = 16;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } ch_state_e;

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchronizer, stability counter FSM, debounced level flop.
// The rise-pulse flop is built only when INPUT_DEBOUNCE_RISE_EN is defined.
module debounce_ch
    import lab_pkg::*;
#(
    parameter int STABLE_CNT = STABLE_CNT_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_din,
    output logic o_db,
    output logic o_rise
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(STABLE_CNT - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_db;
    logic [CNT_W-1:0] r_cnt;
    ch_state_e        r_state;
    logic             w_diff;
    logic             w_fire;

    assign w_diff = (r_sync2 != r_db);
    assign w_fire = w_diff && (r_cnt == TERM);
    assign o_db   = r_db;

    // Two-stage synchronizer for the asynchronous raw input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_din;
            r_sync2 <= r_sync1;
        end
    end

    // Stability FSM: r_state is ST_COUNTING exactly while r_cnt is non-zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_STABLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_db    <= 1'b0;
        end else begin
            case (r_state)
                ST_STABLE: begin
                    if (w_fire) begin
                        r_db <= r_sync2;
                    end else if (w_diff) begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                        r_state <= ST_COUNTING;
                    end else begin
                        r_cnt <= {CNT_W{1'b0}};
                    end
                end
                ST_COUNTING: begin
                    if (!w_diff) begin
                        r_cnt   <= {CNT_W{1'b0}};
                        r_state <= ST_STABLE;
                    end else if (w_fire) begin
                        r_db    <= r_sync2;
                        r_cnt   <= {CNT_W{1'b0}};
                        r_state <= ST_STABLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt   <= {CNT_W{1'b0}};
                    r_state <= ST_STABLE;
                end
            endcase
        end
    end

`ifdef INPUT_DEBOUNCE_RISE_EN
    logic r_rise;

    // Pulse on the same edge that r_db is loaded with a 1 from a 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rise <= 1'b0;
        end else begin
            r_rise <= w_fire && r_sync2;
        end
    end

    assign o_rise = r_rise;
`else
    assign o_rise = 1'b0;
`endif

endmodule

// File: rtl/input_debounce.sv
// Two independent debounced switch channels (A, B) with optional rise pulses.
// Optional feature macro: INPUT_DEBOUNCE_RISE_EN (rise pulses; tied to 0 when undefined).
module input_debounce
    import lab_pkg::*;
#(
    parameter int STABLE_CNT = STABLE_CNT_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    output logic a_db,
    output logic b_db,
    output logic a_rise,
    output logic b_rise
);

    debounce_ch #(
        .STABLE_CNT (STABLE_CNT),
        .CNT_W      (CNT_W)
    ) u_ch_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_din  (a),
        .o_db   (a_db),
        .o_rise (a_rise)
    );

    debounce_ch #(
        .STABLE_CNT (STABLE_CNT),
        .CNT_W      (CNT_W)
    ) u_ch_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_din  (b),
        .o_db   (b_db),
        .o_rise (b_rise)
    );

endmodule

// File: doc/input_debounce.md
INPUT_DEBOUNCE -- requirements
Module: input_debounce

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 4, giving the consecutive stable cycles required before a debounced level changes; legal range 1 to 2**CNT_W.
REQ-002 SHALL have parameter CNT_W, default 16, giving the per-channel stability counter width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; ports: clk, rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 a  input  1  raw, asynchronous, bouncing switch input, channel A.
REQ-007 b  input  1  raw, asynchronous, bouncing switch input, channel B.
REQ-008 a_db  output  1  debounced level, channel A; feeds the downstream two-input gate.
REQ-009 b_db  output  1  debounced level, channel B; feeds the downstream two-input gate.
REQ-010 a_rise  output  1  one-cycle pulse when a_db goes 0->1.
REQ-011 b_rise  output  1  one-cycle pulse when b_db goes 0->1.

Function
REQ-012 Each channel SHALL pass its raw input through a 2-flop synchronizer; the second flop output is the sampled value s.
REQ-013 Each channel SHALL compare s with its db output on every clock edge.
- Equal: counter cleared to 0.
- Different, counter != STABLE_CNT-1: counter increments.
- Different, counter == STABLE_CNT-1: db <= s and counter cleared.
REQ-014 Latency SHALL be exactly STABLE_CNT+2 rising edges from the first edge that samples a stable new raw level to the db change, counting that first edge as edge 1.
REQ-015 Any return of s to the db value before the terminal count SHALL clear the counter, so glitches shorter than STABLE_CNT cycles never reach db.
REQ-016 x_rise SHALL be registered and SHALL assert on the same edge that db goes 0->1; it SHALL deassert on the next edge.
REQ-017 Falling db transitions SHALL produce no pulse.
REQ-018 Channels A and B SHALL be fully independent; simultaneous transitions on both SHALL each meet REQ-014 with no interaction.
REQ-019 The counter SHALL never exceed STABLE_CNT-1 and SHALL never wrap.
REQ-020 No combinational path SHALL exist from any input to any output.

Reset
REQ-021 With rst_n low, the synchronizer flops, counters, a_db, b_db, a_rise and b_rise SHALL clear to 0 immediately, independent of clk.
REQ-022 Reset asserted mid-count SHALL discard the partial count; after release, a high input SHALL need a full STABLE_CNT+2 edges to reach db.
REQ-023 The first rising edge after rst_n deasserts SHALL be treated as a normal sampling edge.

Configuration
REQ-024 The rise-pulse feature SHALL be compiled in or out by the macro INPUT_DEBOUNCE_RISE_EN.
- Defined: a_rise and b_rise behave per REQ-016/017.
- Undefined: ports a_rise and b_rise remain, are tied to constant 0, and no pulse flops are built.

Structure
REQ-025 Shared package lab_pkg SHALL hold the STABLE_CNT and CNT_W default constants, plus a two-state channel enum {ST_STABLE, ST_COUNTING} used for debug visibility.
REQ-026 Per-channel logic (synchronizer, counter, db flop, rise flop) SHALL live in sub-module debounce_ch, instantiated twice.

Verification (STABLE_CNT=4)
REQ-027 Reset check: hold rst_n=0 with a=b=1 -> all outputs read 0 immediately and stay 0 while reset is held.
REQ-028 Clean press: a 0->1 held -> a_db=1 on edge 6; a_rise=1 for exactly that one cycle; b_db stays 0.
REQ-029 Bounce: a toggles 1,0,1,0 every 2 cycles, then held 1 -> a_db stays 0 during the bounce; a_db rises 6 edges after the last stable 1 is first sampled.
REQ-030 Release: a 1->0 held with a_db=1 -> a_db=0 on edge 6; no a_rise pulse.
REQ-031 Simultaneous: a and b rise on the same cycle -> a_db and b_db rise on the same edge, with both rise pulses coincident.
REQ-032 Reset mid-count: rst_n pulsed low at count 2 during an a press, a held 1 -> a_db rises 6 edges after reset release; with INPUT_DEBOUNCE_RISE_EN undefined, a_rise is 0 throughout.
